// File: rtl/eq2_resp_logger.sv
// eq2_resp_logger: capture-and-replay response logger for the 2-bit equality comparator.
//
// Samples {a, b, aeqb} on each sample_tick while capturing, checks aeqb against a locally
// computed a==b reference, stores one record per tick and counts mismatches (saturating).
// Once the session is complete the log is replayed one record per rd_req.
//
// Optional feature macro: EQ2_LOG_STOP_ON_ERR_EN
//   defined   -> capture stops after the first mismatching record has been written
//   undefined -> capture always runs DEPTH samples (default build)

module eq2_resp_logger #(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sample_tick,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             aeqb,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             rd_req,
    output logic [2*W+1:0]   rd_data,
    output logic             rd_valid,
    output logic             rd_empty
);

    // Address width for the log memory; pointers carry one extra bit so that a full
    // log (wr_ptr == DEPTH) is distinguishable from an empty one.
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned RW = 2 * W + 2;

    localparam logic [PW-1:0]    LastPtr = PW'(DEPTH - 1);
    localparam logic [PW-1:0]    PtrOne  = PW'(1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StDone
    } state_e;

    state_e             state_q;
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [RW-1:0]      rd_data_q;
    logic               rd_valid_q;

    // Log storage; contents are not reset, only the pointers define what is valid.
    logic [RW-1:0]      mem [DEPTH];

    logic               ref_eq;
    logic               sample_err;
    logic [RW-1:0]      record;
    logic [CNT_W-1:0]   err_cnt_inc;
    logic               wr_last;
    logic               log_empty;
    logic               capture_en;

    // Reference check and record assembly for the current cycle's inputs.
    always_comb begin
        ref_eq      = (a == b);
        sample_err  = aeqb ^ ref_eq;
        record      = {a, b, aeqb, sample_err};
        err_cnt_inc = (err_cnt_q == CntMax) ? err_cnt_q : (err_cnt_q + CntOne);
        wr_last     = (wr_ptr_q == LastPtr);
        log_empty   = (rd_ptr_q == wr_ptr_q);
        capture_en  = (state_q == StCapture) && sample_tick;
    end

    // Log write port: one record per accepted sample_tick.
    always_ff @(posedge clk) begin
        if (capture_en) begin
            mem[wr_ptr_q[AW-1:0]] <= record;
        end
    end

    // Session FSM with registered status, counters and read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            // rd_valid is a single-cycle pulse unless a read fires below.
            rd_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        wr_ptr_q  <= '0;
                        rd_ptr_q  <= '0;
                        err_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        state_q   <= StCapture;
                    end
                end
                StCapture: begin
                    if (sample_tick) begin
                        wr_ptr_q <= wr_ptr_q + PtrOne;
                        if (sample_err) begin
                            err_cnt_q <= err_cnt_inc;
                        end
                        if (wr_last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
`ifdef EQ2_LOG_STOP_ON_ERR_EN
                        else if (sample_err) begin
                            // Failing record is already written; freeze the log here.
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
`endif
                    end
                end
                StDone: begin
                    // start has priority over a read in the same cycle.
                    if (start) begin
                        wr_ptr_q  <= '0;
                        rd_ptr_q  <= '0;
                        err_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        state_q   <= StCapture;
                    end else if (rd_req && !log_empty) begin
                        rd_data_q  <= mem[rd_ptr_q[AW-1:0]];
                        rd_valid_q <= 1'b1;
                        rd_ptr_q   <= rd_ptr_q + PtrOne;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping; pass and rd_empty decode registered state only.
    always_comb begin
        busy     = busy_q;
        done     = done_q;
        err_cnt  = err_cnt_q;
        rd_data  = rd_data_q;
        rd_valid = rd_valid_q;
        rd_empty = log_empty;
        pass     = done_q && (err_cnt_q == '0);
    end

endmodule

// File: tb/tb_eq2_resp_logger.sv
// Scoreboard bench for eq2_resp_logger: the driver pushes the hand-computed record for
// every read it expects to succeed, and a negedge monitor pops/compares on rd_valid.

module tb_eq2_resp_logger;

    localparam int unsigned W     = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             sample_tick;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             aeqb;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic             rd_req;
    logic [2*W+1:0]   rd_data;
    logic             rd_valid;
    logic             rd_empty;

    int tests;
    int fails;

    logic [5:0] exp_q [$];
    logic       req_expect;
    logic       exp_valid;

    // Stimulus patterns and hand-computed records {a, b, aeqb, err}.
    logic [1:0] pat_a     [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1};
    logic [1:0] pat_b     [8] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd2, 2'd0};
    logic       pat_eq    [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [5:0] good_rec  [8] = '{6'b00_00_1_0, 6'b00_01_0_0, 6'b01_01_1_0, 6'b10_11_0_0,
                                  6'b11_11_1_0, 6'b11_00_0_0, 6'b10_10_1_0, 6'b01_00_0_0};
    logic [5:0] fault_rec [8] = '{6'b00_00_0_1, 6'b00_01_0_0, 6'b01_01_0_1, 6'b10_11_0_0,
                                  6'b11_11_0_1, 6'b11_00_0_0, 6'b10_10_0_1, 6'b01_00_0_0};

    eq2_resp_logger #(
        .W     (W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .sample_tick (sample_tick),
        .a           (a),
        .b           (b),
        .aeqb        (aeqb),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_cnt     (err_cnt),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_empty    (rd_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A read request accepted at an edge must show rd_valid right after that edge.
    always @(posedge clk) exp_valid <= req_expect;

    // Monitor: compares every rd_valid pulse against the scoreboard queue.
    always @(negedge clk) begin
        if (rd_valid === 1'b1 || exp_valid === 1'b1) begin
            check("rd_valid_timing", {31'd0, rd_valid}, {31'd0, exp_valid});
        end
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rd_valid_unexpected", 32'd1, 32'd0);
            end else begin
                check("rd_data", {26'd0, rd_data}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [1:0] ta, input logic [1:0] tbv, input logic te);
        a           = ta;
        b           = tbv;
        aeqb        = te;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    // Start pulse with a coincident sample_tick that must not be captured.
    task automatic start_session();
        start       = 1'b1;
        sample_tick = 1'b1;
        a           = 2'd1;
        b           = 2'd1;
        aeqb        = 1'b1;
        step();
        start       = 1'b0;
        sample_tick = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_after_start", {31'd0, done}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},     {31'd0, busy},     32'd0);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_pass"},     {31'd0, pass},     32'd0);
        check({tag, "_err_cnt"},  {28'd0, err_cnt},  32'd0);
        check({tag, "_rd_data"},  {26'd0, rd_data},  32'd0);
        check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        check({tag, "_rd_empty"}, {31'd0, rd_empty}, 32'd1);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        sample_tick = 1'b0;
        a           = '0;
        b           = '0;
        aeqb        = 1'b0;
        rd_req      = 1'b0;
        req_expect  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset_n = 1'b1;
        step();

        // Idle: sample_tick is ignored.
        tick(2'd1, 2'd1, 1'b1);
        step();
        check("idle_busy",     {31'd0, busy},     32'd0);
        check("idle_done",     {31'd0, done},     32'd0);
        check("idle_rd_empty", {31'd0, rd_empty}, 32'd1);
        check("idle_err_cnt",  {28'd0, err_cnt},  32'd0);

        // Session 1: correct DUT, replay with rd_req held for 10 cycles.
        start_session();
        for (int i = 0; i < 8; i++) tick(pat_a[i], pat_b[i], pat_eq[i]);
        check("s1_done",     {31'd0, done},     32'd1);
        check("s1_busy",     {31'd0, busy},     32'd0);
        check("s1_pass",     {31'd0, pass},     32'd1);
        check("s1_err_cnt",  {28'd0, err_cnt},  32'd0);
        check("s1_rd_empty", {31'd0, rd_empty}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            rd_req     = 1'b1;
            req_expect = (i < 8);
            if (i < 8) exp_q.push_back(good_rec[i]);
            step();
        end
        rd_req     = 1'b0;
        req_expect = 1'b0;
        step();
        check("s1_empty_after_reads", {31'd0, rd_empty}, 32'd1);
        check("s1_rd_data_holds",     {26'd0, rd_data},  {26'd0, good_rec[7]});
        check("s1_queue_drained",     exp_q.size(),      32'd0);

`ifndef EQ2_LOG_STOP_ON_ERR_EN
        // Session 2: faulty DUT (aeqb stuck at 0); capture runs through the errors.
        start_session();
        tick(pat_a[0], pat_b[0], 1'b0);
        check("s2_err_cnt_first", {28'd0, err_cnt}, 32'd1);
        check("s2_busy_on_err",   {31'd0, busy},    32'd1);
        for (int i = 1; i < 8; i++) tick(pat_a[i], pat_b[i], 1'b0);
        check("s2_done",    {31'd0, done},    32'd1);
        check("s2_err_cnt", {28'd0, err_cnt}, 32'd4);
        check("s2_pass",    {31'd0, pass},    32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_req     = 1'b1;
            req_expect = 1'b1;
            exp_q.push_back(fault_rec[i]);
            step();
            rd_req     = 1'b0;
            req_expect = 1'b0;
            step();
        end
        check("s2_rd_empty", {31'd0, rd_empty}, 32'd1);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        step();
        check("s2_read_on_empty_holds", {26'd0, rd_data}, {26'd0, fault_rec[7]});
`endif

        // Session 3: partial read, then start collides with rd_req.
        start_session();
        for (int i = 0; i < 8; i++) tick(pat_a[i], pat_b[i], pat_eq[i]);
        for (int i = 0; i < 2; i++) begin
            rd_req     = 1'b1;
            req_expect = 1'b1;
            exp_q.push_back(good_rec[i]);
            step();
        end
        start      = 1'b1;
        rd_req     = 1'b1;
        req_expect = 1'b0;
        step();
        start  = 1'b0;
        rd_req = 1'b0;
        check("coll_busy",     {31'd0, busy},     32'd1);
        check("coll_done",     {31'd0, done},     32'd0);
        check("coll_rd_empty", {31'd0, rd_empty}, 32'd1);
        check("coll_err_cnt",  {28'd0, err_cnt},  32'd0);

        // Session 4 (started by the collision): reset after 3 ticks.
        tick(2'd0, 2'd0, 1'b0);
        tick(2'd2, 2'd1, 1'b0);
        tick(2'd3, 2'd3, 1'b1);
        check("s4_err_cnt", {28'd0, err_cnt}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        step();

`ifdef EQ2_LOG_STOP_ON_ERR_EN
        // Stop on first error: mismatch at tick 3.
        start_session();
        tick(2'd0, 2'd0, 1'b1);
        tick(2'd0, 2'd1, 1'b0);
        tick(2'd1, 2'd1, 1'b0);
        check("stop_done",    {31'd0, done},    32'd1);
        check("stop_busy",    {31'd0, busy},    32'd0);
        check("stop_err_cnt", {28'd0, err_cnt}, 32'd1);
        tick(2'd2, 2'd2, 1'b0);
        check("stop_err_cnt_frozen", {28'd0, err_cnt}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd_req     = 1'b1;
            req_expect = (i < 3);
            if (i == 0) exp_q.push_back(6'b00_00_1_0);
            if (i == 1) exp_q.push_back(6'b00_01_0_0);
            if (i == 2) exp_q.push_back(6'b01_01_0_1);
            step();
        end
        rd_req     = 1'b0;
        req_expect = 1'b0;
        step();
        check("stop_rd_empty", {31'd0, rd_empty}, 32'd1);
`endif

        step();
        check("final_queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
